nibble_serial_add_arbiter: RTL and testbench

NIBBLE_SERIAL_ADD_ARBITER -- requirements
Module: nibble_serial_add_arbiter

---
 rtl/nibble_serial_add_arbiter.sv | 151 +++++++++++++++
 tb/tb_nibble_serial_add_arbiter.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/nibble_serial_add_arbiter.sv
// nibble_serial_add_arbiter
//   Two requesters share one 4-bit carry-skip adder slice. An accepted
//   operation is summed one nibble per cycle, LSB nibble first. The result
//   is then held until the consumer takes it. Simultaneous requests are
//   arbitrated round-robin.
//
// Ports
//   clk, rst_n                    clock, synchronous active-low reset
//   reqX_valid/_a/_b/_cin         requester X offers an add (X = 0, 1)
//   reqX_ready                    requester X accepted this cycle (IDLE only)
//   res_valid/res_ready           result handshake
//   res_sum, res_cout             sum modulo 2^WIDTH, carry out of the MSB
//   res_id                        requester that owns the result
//   res_skips                     nibbles whose propagate group was all ones
//   busy                          operation in progress (RUN or DONE)
module nibble_serial_add_arbiter #(
  parameter int WIDTH = 16
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           req0_valid,
  input  logic [WIDTH-1:0]               req0_a,
  input  logic [WIDTH-1:0]               req0_b,
  input  logic                           req0_cin,
  output logic                           req0_ready,
  input  logic                           req1_valid,
  input  logic [WIDTH-1:0]               req1_a,
  input  logic [WIDTH-1:0]               req1_b,
  input  logic                           req1_cin,
  output logic                           req1_ready,
  output logic                           res_valid,
  input  logic                           res_ready,
  output logic [WIDTH-1:0]               res_sum,
  output logic                           res_cout,
  output logic                           res_id,
  output logic [$clog2(WIDTH/4+1)-1:0]   res_skips,
  output logic                           busy
);

  localparam int N    = WIDTH / 4;
  localparam int IDXW = (N > 1) ? $clog2(N) : 1;
  localparam int SKW  = $clog2(N + 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t              state_q;
  logic [WIDTH-1:0]    a_q, b_q;
  logic                carry_q;
  logic [IDXW-1:0]     idx_q;
  logic [WIDTH-1:0]    res_sum_q;
  logic                res_cout_q;
  logic                res_id_q;
  logic [SKW-1:0]      res_skips_q;
  logic                last_grant_q;

  // 4-bit carry-skip slice: ripple inside the nibble, but when every bit
  // propagates the carry-in bypasses the ripple chain. Returns {cout, sum}.
  function automatic logic [4:0] csa4(input logic [3:0] a, input logic [3:0] b,
                                      input logic c);
    logic [3:0] p, g;
    logic [4:0] cr;
    p     = a ^ b;
    g     = a & b;
    cr[0] = c;
    for (int i = 0; i < 4; i++) cr[i+1] = g[i] | (p[i] & cr[i]);
    return {((&p) ? c : cr[4]), p ^ cr[3:0]};
  endfunction

  // Round-robin: on a tie the requester not granted last wins.
  logic grant;
  logic accept;

  always_comb begin
    grant = 1'b0;
    if (req0_valid && req1_valid) grant = ~last_grant_q;
    else                          grant = req1_valid;
  end

  assign accept     = rst_n && (state_q == IDLE) && (req0_valid || req1_valid);
  assign req0_ready = accept && !grant;
  assign req1_ready = accept &&  grant;

  // The single shared slice works on nibble idx_q of the latched operands.
  logic [3:0] nib_a, nib_b, nib_p;
  logic [4:0] slice;

  assign nib_a = a_q[{idx_q, 2'b00} +: 4];
  assign nib_b = b_q[{idx_q, 2'b00} +: 4];
  assign nib_p = nib_a ^ nib_b;
  assign slice = csa4(nib_a, nib_b, carry_q);

  // Operand latches carry no reset; they are only read after acceptance.
  always_ff @(posedge clk) begin
    if (accept) begin
      a_q <= grant ? req1_a : req0_a;
      b_q <= grant ? req1_b : req0_b;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      carry_q      <= 1'b0;
      idx_q        <= '0;
      res_sum_q    <= '0;
      res_cout_q   <= 1'b0;
      res_id_q     <= 1'b0;
      res_skips_q  <= '0;
      last_grant_q <= 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            carry_q     <= grant ? req1_cin : req0_cin;
            res_id_q    <= grant;
            idx_q       <= '0;
            res_sum_q   <= '0;
            res_skips_q <= '0;
            state_q     <= RUN;
          end
        end
        RUN: begin
          res_sum_q[{idx_q, 2'b00} +: 4] <= slice[3:0];
          carry_q    <= slice[4];
          res_cout_q <= slice[4];
          if (&nib_p) res_skips_q <= res_skips_q + SKW'(1);
          if (idx_q == IDXW'(N - 1)) begin
            state_q <= DONE;
          end else begin
            idx_q <= idx_q + IDXW'(1);
          end
        end
        DONE: begin
          if (res_ready) begin
            last_grant_q <= res_id_q;
            state_q      <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign res_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign res_sum   = res_sum_q;
  assign res_cout  = res_cout_q;
  assign res_id    = res_id_q;
  assign res_skips = res_skips_q;

endmodule

// File: tb/tb_nibble_serial_add_arbiter.sv
module tb_nibble_serial_add_arbiter;

  localparam int WIDTH = 16;
  localparam int N     = WIDTH / 4;

  logic              clk;
  logic              rst_n;
  logic              req0_valid, req1_valid;
  logic [WIDTH-1:0]  req0_a, req0_b, req1_a, req1_b;
  logic              req0_cin, req1_cin;
  logic              req0_ready, req1_ready;
  logic              res_valid, res_ready;
  logic [WIDTH-1:0]  res_sum;
  logic              res_cout, res_id;
  logic [2:0]        res_skips;
  logic              busy;

  int total  = 0;
  int passed = 0;

  nibble_serial_add_arbiter #(.WIDTH(WIDTH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req0_valid (req0_valid),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req0_cin   (req0_cin),
    .req0_ready (req0_ready),
    .req1_valid (req1_valid),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .req1_cin   (req1_cin),
    .req1_ready (req1_ready),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .res_sum    (res_sum),
    .res_cout   (res_cout),
    .res_id     (res_id),
    .res_skips  (res_skips),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Offer one operation on requester id, wait for the result, check it,
  // take it immediately and confirm the return to IDLE. Starts at a negedge.
  task automatic do_op(input string tag, input logic id, input logic [15:0] a,
                       input logic [15:0] b, input logic cin, input logic [15:0] exp_sum,
                       input logic exp_cout, input logic [2:0] exp_skips);
    int lat;
    if (id) begin
      req1_valid = 1'b1; req1_a = a; req1_b = b; req1_cin = cin;
    end else begin
      req0_valid = 1'b1; req0_a = a; req0_b = b; req0_cin = cin;
    end
    #1;
    check({tag, "_ready"}, {30'd0, req1_ready, req0_ready}, id ? 32'd2 : 32'd1);
    @(posedge clk);
    @(negedge clk);
    // Withdraw and scramble operands: the latched copy must be used.
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_a = ~a; req0_b = ~b; req1_a = ~a; req1_b = ~b;
    lat = 1;
    while (!res_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check({tag, "_latency"}, lat, N + 1);
    check({tag, "_sum"},   res_sum,   exp_sum);
    check({tag, "_cout"},  res_cout,  exp_cout);
    check({tag, "_id"},    res_id,    id);
    check({tag, "_skips"}, res_skips, exp_skips);
    res_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    res_ready = 1'b0;
    check({tag, "_after_valid"}, res_valid, 1'b0);
    check({tag, "_after_busy"},  busy,      1'b0);
    check({tag, "_after_hold"},  res_sum,   exp_sum);
  endtask

  initial begin
    rst_n = 1'b0;
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_a = '0; req0_b = '0; req0_cin = 1'b0;
    req1_a = '0; req1_b = '0; req1_cin = 1'b0;
    res_ready = 1'b0;

    // Reset: readies stay low even with requests offered.
    @(negedge clk);
    req0_valid = 1'b1; req1_valid = 1'b1;
    #1;
    check("rst_ready", {30'd0, req1_ready, req0_ready}, 32'd0);
    @(negedge clk);
    check("rst_busy",  busy,      1'b0);
    check("rst_valid", res_valid, 1'b0);
    check("rst_sum",   res_sum,   16'h0000);
    check("rst_cout",  res_cout,  1'b0);
    check("rst_id",    res_id,    1'b0);
    check("rst_skips", res_skips, 3'd0);
    req0_valid = 1'b0; req1_valid = 1'b0;
    rst_n = 1'b1;

    // Directed operations.
    do_op("op_basic", 1'b0, 16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 3'd0);
    do_op("op_skip4", 1'b1, 16'h0F0F, 16'hF0F0, 1'b1, 16'h0000, 1'b1, 3'd4);
    do_op("op_wrap",  1'b0, 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 3'd3);

    // Round-robin with both requesters valid continuously after reset.
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    req0_valid = 1'b1; req0_a = 16'h0001; req0_b = 16'h0002; req0_cin = 1'b0;
    req1_valid = 1'b1; req1_a = 16'h1000; req1_b = 16'h2000; req1_cin = 1'b0;
    res_ready  = 1'b1;
    for (int op = 0; op < 4; op++) begin
      #1;
      check("rr_grant", {30'd0, req1_ready, req0_ready}, (op % 2) ? 32'd2 : 32'd1);
      @(posedge clk);
      for (int k = 1; k <= N + 1; k++) begin
        @(negedge clk);
        check("rr_ready_low", {30'd0, req1_ready, req0_ready}, 32'd0);
      end
      check("rr_valid", res_valid, 1'b1);
      check("rr_id",    res_id,    (op % 2) ? 1'b1 : 1'b0);
      check("rr_sum",   res_sum,   (op % 2) ? 16'h3000 : 16'h0003);
      @(posedge clk);
      @(negedge clk);
    end
    req0_valid = 1'b0; req1_valid = 1'b0; res_ready = 1'b0;

    // Consumer stalls three cycles in DONE.
    @(negedge clk);
    req0_valid = 1'b1; req0_a = 16'h8F00; req0_b = 16'h70F0; req0_cin = 1'b0;
    @(posedge clk);
    for (int k = 1; k <= N + 1; k++) @(negedge clk);
    req1_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      check("stall_valid", res_valid, 1'b1);
      check("stall_sum",   res_sum,   16'hFFF0);
      check("stall_skips", res_skips, 3'd3);
      check("stall_ready", {30'd0, req1_ready, req0_ready}, 32'd0);
      @(negedge clk);
    end
    check("stall_valid4", res_valid, 1'b1);
    res_ready = 1'b1; req0_valid = 1'b0; req1_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    res_ready = 1'b0;
    check("stall_idle_busy",  busy,      1'b0);
    check("stall_idle_valid", res_valid, 1'b0);

    // Reset in the middle of RUN (idx 2) abandons the operation.
    req1_valid = 1'b1; req1_a = 16'h1111; req1_b = 16'h1111; req1_cin = 1'b0;
    #1;
    check("mid_grant", {30'd0, req1_ready, req0_ready}, 32'd2);
    @(posedge clk);
    @(negedge clk);
    req1_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("mid_busy_run", busy, 1'b1);
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("mid_busy",  busy,      1'b0);
    check("mid_valid", res_valid, 1'b0);
    check("mid_sum",   res_sum,   16'h0000);
    rst_n = 1'b1;
    req0_valid = 1'b1; req1_valid = 1'b1;
    #1;
    check("mid_tie_grant", {30'd0, req1_ready, req0_ready}, 32'd1);
    req0_valid = 1'b0; req1_valid = 1'b0;

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
